// File: rtl/uart_pkg.sv
// Shared UART definitions.
// Holds the receiver state encoding and the default frame/oversample settings.
// The baud generator and the transmitter use the same defaults, so the three blocks agree.
// No ports.
package uart_pkg;

   localparam int unsigned DEFAULT_OVERSAMPLE = 16;
   localparam int unsigned DEFAULT_DATA_BITS  = 8;

   // PARITY is only reached when the receiver is built with parity support.
   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      PARITY,
      STOP,
      WAIT_IDLE
   } rx_state_t;

endpackage

// File: rtl/sync_2ff.sv
// Generic two-flop synchroniser for a single asynchronous level.
// Both stages reset to ResetVal, so a line that idles at that level shows no edge after reset.
// Ports:
//   clk_i  - destination clock
//   arst_i - asynchronous reset, active-high
//   d_i    - asynchronous input
//   q_o    - synchronised output, two clk_i cycles of latency
module sync_2ff #(
   parameter logic ResetVal = 1'b1
) (
   input  logic clk_i,
   input  logic arst_i,
   input  logic d_i,
   output logic q_o
);

   logic meta_q;
   logic sync_q;

   always_ff @(posedge clk_i or posedge arst_i) begin
      if (arst_i) begin
         meta_q <= ResetVal;
         sync_q <= ResetVal;
      end else begin
         meta_q <= d_i;
         sync_q <= meta_q;
      end
   end

   assign q_o = sync_q;

endmodule

// File: rtl/uart_rx.sv
// UART receiver that turns the serial rx line into parallel words.
// It has no baud logic of its own: the counters only move on the external 16x tick.
// Received words are handed to the host through a valid/ready handshake.
// Framing errors and overruns are reported as single-cycle pulses.
//
// Optional build macro UART_RX_PARITY_EN:
//   - adds an even-parity bit after the data bits;
//   - adds the parity_err output.
//   Without the macro the frame format is 8N1.
//
// Ports:
//   clk         - system clock
//   arst        - asynchronous reset, active-high
//   tick        - one-cycle oversample strobe, OVERSAMPLE per bit period
//   rx          - asynchronous serial input, idle high
//   rx_data     - received word; stable while rx_valid is high
//   rx_valid    - word available; held until rx_ready accepts it
//   rx_ready    - host accept; a transfer happens when rx_valid & rx_ready
//   frame_err   - one-cycle pulse when the stop bit is sampled low
//   overrun_err - one-cycle pulse when a frame completes while the previous word is unaccepted
//   parity_err  - (UART_RX_PARITY_EN only) one-cycle pulse on an even-parity mismatch
module uart_rx
   import uart_pkg::*;
#(
   parameter int unsigned DATA_BITS  = DEFAULT_DATA_BITS,
   parameter int unsigned OVERSAMPLE = DEFAULT_OVERSAMPLE
) (
   input  logic                 clk,
   input  logic                 arst,
   input  logic                 tick,
   input  logic                 rx,
   output logic [DATA_BITS-1:0] rx_data,
   output logic                 rx_valid,
   input  logic                 rx_ready,
   output logic                 frame_err,
   output logic                 overrun_err
`ifdef UART_RX_PARITY_EN
  ,output logic                 parity_err
`endif
);

   localparam int unsigned    SCW    = $clog2(OVERSAMPLE);
   localparam logic [SCW-1:0] S_MID  = SCW'(OVERSAMPLE / 2 - 1);
   localparam logic [SCW-1:0] S_LAST = SCW'(OVERSAMPLE - 1);
   localparam logic [2:0]     B_LAST = 3'(DATA_BITS - 1);

   logic rx_s;

   rx_state_t            state_q, state_d;
   logic [SCW-1:0]       s_cnt_q, s_cnt_d;
   logic [2:0]           b_cnt_q, b_cnt_d;
   logic [DATA_BITS-1:0] shreg_q, shreg_d;
   logic [DATA_BITS-1:0] rx_data_q, rx_data_d;
   logic                 rx_valid_q, rx_valid_d;
   logic                 frame_err_q, frame_err_d;
   logic                 overrun_err_q, overrun_err_d;
   logic                 accept;
   logic                 par_bad;

`ifdef UART_RX_PARITY_EN
   logic par_bad_q, par_bad_d;
   logic parity_err_q, parity_err_d;

   assign par_bad = par_bad_q;
`else
   assign par_bad = 1'b0;
`endif

   sync_2ff #(
      .ResetVal(1'b1)
   ) u_sync (
      .clk_i (clk),
      .arst_i(arst),
      .d_i   (rx),
      .q_o   (rx_s)
   );

   assign accept = rx_valid_q & rx_ready;

   always_comb begin
      state_d       = state_q;
      s_cnt_d       = s_cnt_q;
      b_cnt_d       = b_cnt_q;
      shreg_d       = shreg_q;
      rx_data_d     = rx_data_q;
      // An acceptance this cycle frees the output register; a load below may refill it.
      rx_valid_d    = accept ? 1'b0 : rx_valid_q;
      frame_err_d   = 1'b0;
      overrun_err_d = 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bad_d     = par_bad_q;
      parity_err_d  = 1'b0;
`endif

      unique case (state_q)
         // The falling-edge detect runs every clk, not just on ticks.
         IDLE: begin
            if (!rx_s) begin
               state_d = START;
               s_cnt_d = '0;
            end
         end

         START: begin
            if (tick) begin
               if (s_cnt_q == S_MID) begin
                  // Re-check the line at mid start bit so short glitches are rejected.
                  s_cnt_d = '0;
                  if (rx_s) begin
                     state_d = IDLE;
                  end else begin
                     state_d = DATA;
                     b_cnt_d = '0;
`ifdef UART_RX_PARITY_EN
                     par_bad_d = 1'b0;
`endif
                  end
               end else begin
                  s_cnt_d = s_cnt_q + SCW'(1);
               end
            end
         end

         DATA: begin
            if (tick) begin
               if (s_cnt_q == S_LAST) begin
                  s_cnt_d = '0;
                  shreg_d = {rx_s, shreg_q[DATA_BITS-1:1]};
                  if (b_cnt_q == B_LAST) begin
                     b_cnt_d = '0;
`ifdef UART_RX_PARITY_EN
                     state_d = PARITY;
`else
                     state_d = STOP;
`endif
                  end else begin
                     b_cnt_d = b_cnt_q + 3'd1;
                  end
               end else begin
                  s_cnt_d = s_cnt_q + SCW'(1);
               end
            end
         end

`ifdef UART_RX_PARITY_EN
         PARITY: begin
            if (tick) begin
               if (s_cnt_q == S_LAST) begin
                  s_cnt_d = '0;
                  state_d = STOP;
                  // Even parity: data bits plus parity bit must XOR to zero.
                  if ((^shreg_q) ^ rx_s) begin
                     par_bad_d    = 1'b1;
                     parity_err_d = 1'b1;
                  end
               end else begin
                  s_cnt_d = s_cnt_q + SCW'(1);
               end
            end
         end
`endif

         STOP: begin
            if (tick) begin
               if (s_cnt_q == S_LAST) begin
                  s_cnt_d = '0;
`ifdef UART_RX_PARITY_EN
                  par_bad_d = 1'b0;
`endif
                  if (!rx_s) begin
                     frame_err_d = 1'b1;
                     state_d     = WAIT_IDLE;
                  end else begin
                     state_d = IDLE;
                     // A word that failed parity is dropped silently here.
                     if (!par_bad) begin
                        if (!rx_valid_q || accept) begin
                           rx_data_d  = shreg_q;
                           rx_valid_d = 1'b1;
                        end else begin
                           overrun_err_d = 1'b1;
                        end
                     end
                  end
               end else begin
                  s_cnt_d = s_cnt_q + SCW'(1);
               end
            end
         end

         // Hold off until the line goes high again, so a break does not look like a new frame.
         WAIT_IDLE: begin
            if (rx_s) begin
               state_d = IDLE;
            end
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge arst) begin
      if (arst) begin
         state_q       <= IDLE;
         s_cnt_q       <= '0;
         b_cnt_q       <= '0;
         shreg_q       <= '0;
         rx_data_q     <= '0;
         rx_valid_q    <= 1'b0;
         frame_err_q   <= 1'b0;
         overrun_err_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         s_cnt_q       <= s_cnt_d;
         b_cnt_q       <= b_cnt_d;
         shreg_q       <= shreg_d;
         rx_data_q     <= rx_data_d;
         rx_valid_q    <= rx_valid_d;
         frame_err_q   <= frame_err_d;
         overrun_err_q <= overrun_err_d;
      end
   end

`ifdef UART_RX_PARITY_EN
   always_ff @(posedge clk or posedge arst) begin
      if (arst) begin
         par_bad_q    <= 1'b0;
         parity_err_q <= 1'b0;
      end else begin
         par_bad_q    <= par_bad_d;
         parity_err_q <= parity_err_d;
      end
   end

   assign parity_err = parity_err_q;
`endif

   assign rx_data     = rx_data_q;
   assign rx_valid    = rx_valid_q;
   assign frame_err   = frame_err_q;
   assign overrun_err = overrun_err_q;

endmodule
